// File: rtl/arima_pkg.sv
// Shared types and constants for the ARIMA sequencing controller.
// The order-check feature in arima_seq_ctrl is enabled by defining
// ARIMA_SEQ_CTRL_ORDER_CHK_EN.
package arima_pkg;

    localparam int unsigned MAX_ORDER = 10;

    typedef enum logic [1:0] {
        HOLD   = 2'b00,
        LOAD   = 2'b01,
        UPDATE = 2'b10,
        CLEAR  = 2'b11
    } ctrl_e;

    typedef enum logic [3:0] {
        IDLE,
        CFG,
        WAIT_IN,
        DIFF,
        ARMA,
        INTE,
        OUT,
        NEXT,
        DONE,
        ERR
    } seq_state_e;

    // Registered output bundle; err is handled separately because it only
    // exists when the order check is built in.
    typedef struct packed {
        ctrl_e c_diff;
        ctrl_e c_ar;
        ctrl_e c_ma;
        ctrl_e c_inte;
        logic  sel_inte_in;
        logic  in_ready;
        logic  out_valid;
        logic  busy;
        logic  done;
    } seq_out_t;

    localparam seq_out_t SEQ_OUT_RST = '{
        c_diff:      HOLD,
        c_ar:        HOLD,
        c_ma:        HOLD,
        c_inte:      HOLD,
        sel_inte_in: 1'b1,
        in_ready:    1'b0,
        out_valid:   1'b0,
        busy:        1'b0,
        done:        1'b0
    };

endpackage

// File: rtl/arima_warmup_cnt.sv
// Job bookkeeping for arima_seq_ctrl: captured orders, warm-up length
// W = d + max(p, q), and the accepted-sample counter with its flags.
module arima_warmup_cnt #(
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned MAX_ORDER = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             capture_i,
    input  logic             inc_i,
    input  logic [31:0]      p_i,
    input  logic [31:0]      d_i,
    input  logic [31:0]      q_i,
    input  logic [CNT_W-1:0] n_i,
    output logic             in_warmup_o,
    output logic             last_sample_o,
    output logic             n_zero_o,
    output logic             order_err_o
);
    import arima_pkg::*;

    logic [31:0]      p_q, d_q, q_q;
    logic [CNT_W-1:0] n_q;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      w;

    // Capture the job parameters on start; count accepted samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_q   <= '0;
            d_q   <= '0;
            q_q   <= '0;
            n_q   <= '0;
            cnt_q <= '0;
        end else if (capture_i) begin
            p_q   <= p_i;
            d_q   <= d_i;
            q_q   <= q_i;
            n_q   <= n_i;
            cnt_q <= '0;
        end else if (inc_i) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Warm-up length and the flags the sequencer branches on. The counter
    // never wraps because a job has fewer than 2^CNT_W samples.
    always_comb begin
        w             = d_q + ((p_q > q_q) ? p_q : q_q);
        in_warmup_o   = (32'(cnt_q) <= w);
        last_sample_o = (cnt_q == n_q);
        n_zero_o      = (n_q == '0);
        order_err_o   = (p_q > MAX_ORDER) || (q_q > MAX_ORDER) || (d_q > MAX_ORDER);
    end

endmodule

// File: rtl/arima_seq_ctrl.sv
// Sequencer for the ARIMA datapath (diff -> ar/ma -> inte). Outputs are a
// registered Moore decode of the state, so in_valid/out_ready never reach
// the c_* codes combinationally.
// Optional: define ARIMA_SEQ_CTRL_ORDER_CHK_EN to trap p/q/d > MAX_ORDER
// in an ERR state; otherwise err is tied low.
module arima_seq_ctrl #(
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned MAX_ORDER = arima_pkg::MAX_ORDER
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      p_order,
    input  logic [31:0]      d_order,
    input  logic [31:0]      q_order,
    input  logic [CNT_W-1:0] n_samples,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       c_diff,
    output logic [1:0]       c_ar,
    output logic [1:0]       c_ma,
    output logic [1:0]       c_inte,
    output logic             sel_inte_in,
    output logic             busy,
    output logic             done,
    output logic             err
);
    import arima_pkg::*;

    seq_state_e state_q, state_d;
    seq_out_t   out_q;
    logic       in_warmup, last_sample, n_zero, order_err;
    logic       capture, inc;

    assign capture = (state_q == IDLE) && start;
    assign inc     = (state_q == WAIT_IN) && in_valid;

    arima_warmup_cnt #(
        .CNT_W     (CNT_W),
        .MAX_ORDER (MAX_ORDER)
    ) u_warmup_cnt (
        .clk           (clk),
        .rst           (rst),
        .capture_i     (capture),
        .inc_i         (inc),
        .p_i           (p_order),
        .d_i           (d_order),
        .q_i           (q_order),
        .n_i           (n_samples),
        .in_warmup_o   (in_warmup),
        .last_sample_o (last_sample),
        .n_zero_o      (n_zero),
        .order_err_o   (order_err)
    );

    // Output decode for a given state. sel only matters while the integrator
    // updates; the warm-up flag is stable from DIFF through INTE.
    function automatic seq_out_t decode(seq_state_e s, logic warm);
        seq_out_t o;
        o = SEQ_OUT_RST;
        case (s)
            IDLE:    ;
            CFG: begin
                o.c_diff = CLEAR;
                o.c_ar   = CLEAR;
                o.c_ma   = CLEAR;
                o.c_inte = CLEAR;
                o.busy   = 1'b1;
            end
            WAIT_IN: begin
                o.in_ready = 1'b1;
                o.busy     = 1'b1;
            end
            DIFF: begin
                o.c_diff = UPDATE;
                o.busy   = 1'b1;
            end
            ARMA: begin
                o.c_ar        = UPDATE;
                o.c_ma        = UPDATE;
                o.sel_inte_in = warm;
                o.busy        = 1'b1;
            end
            INTE: begin
                o.c_inte      = UPDATE;
                o.sel_inte_in = warm;
                o.busy        = 1'b1;
            end
            OUT: begin
                o.out_valid = 1'b1;
                o.busy      = 1'b1;
            end
            NEXT:    o.busy = 1'b1;
            DONE: begin
                o.done = 1'b1;
                o.busy = 1'b1;
            end
            ERR:     o.busy = 1'b1;
            default: ;
        endcase
        return o;
    endfunction

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = CFG;
            CFG: begin
                state_d = n_zero ? DONE : WAIT_IN;
`ifdef ARIMA_SEQ_CTRL_ORDER_CHK_EN
                if (order_err) state_d = ERR;
`endif
            end
            WAIT_IN: if (in_valid) state_d = DIFF;
            DIFF:    state_d = ARMA;
            ARMA:    state_d = INTE;
            INTE:    state_d = in_warmup ? NEXT : OUT;
            OUT:     if (out_ready) state_d = NEXT;
            NEXT:    state_d = last_sample ? DONE : WAIT_IN;
            DONE:    state_d = IDLE;
`ifdef ARIMA_SEQ_CTRL_ORDER_CHK_EN
            ERR:     if (start) state_d = IDLE;
`else
            ERR:     state_d = IDLE;
`endif
            default: state_d = IDLE;
        endcase
    end

    // State register with outputs registered from the state being entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            out_q   <= SEQ_OUT_RST;
        end else begin
            state_q <= state_d;
            out_q   <= decode(state_d, in_warmup);
        end
    end

    assign c_diff      = out_q.c_diff;
    assign c_ar        = out_q.c_ar;
    assign c_ma        = out_q.c_ma;
    assign c_inte      = out_q.c_inte;
    assign sel_inte_in = out_q.sel_inte_in;
    assign in_ready    = out_q.in_ready;
    assign out_valid   = out_q.out_valid;
    assign busy        = out_q.busy;
    assign done        = out_q.done;

`ifdef ARIMA_SEQ_CTRL_ORDER_CHK_EN
    logic err_q;

    // Error flag follows entry into and exit from ERR.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= (state_d == ERR);
    end

    assign err = err_q;
`else
    logic unused_order_err;
    assign unused_order_err = order_err;
    assign err              = 1'b0;
`endif

endmodule
